// File: rtl/srt_div_stream.sv
// srt_div_stream: radix-2 SRT iterative divider with valid/ready handshake,
// per-request signed/unsigned mode, tag pass-through and div-by-zero/overflow flags.
module srt_div_stream #(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_in,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     q,
    output logic [N-1:0]     r,
    output logic [TAG_W-1:0] tag_out,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int W  = N + 2;
    localparam int SW = $clog2(N);
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic             sgn_q, sgn_d, qs_q, qs_d, rs_q, rs_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [N-1:0]     dl_q, dl_d, dn_q, dn_d, qp_q, qp_d, qn_q, qn_d, q_q, q_d, r_q, r_d;
    logic [W-1:0]     w_q, w_d;
    logic [SW-1:0]    cnt_q, cnt_d, sh_q, sh_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // In PREP, dl_q/dn_q still hold the raw dividend/divisor captured at acceptance.
    logic          sx, sy, pos, neg, neg_w;
    logic [N-1:0]  ax, ay, qm, rn, rm;
    logic [SW-1:0] lz;
    logic [2*N-1:0] xs;
    logic [W-1:0]  pw, dnw;
    logic [2:0]    top;

    assign sx    = sgn_q & dl_q[N-1];
    assign sy    = sgn_q & dn_q[N-1];
    assign ax    = sx ? -dl_q : dl_q;
    assign ay    = sy ? -dn_q : dn_q;
    assign xs    = {{N{1'b0}}, ax} << lz;
    assign dnw   = {2'b00, dn_q};
    assign pw    = {w_q[W-2:0], dl_q[N-1]};
    assign top   = pw[W-1:W-3];
    assign pos   = !top[2] && (top[1:0] != 2'b00);
    assign neg   = top[2] && (top[1:0] != 2'b11);
    assign neg_w = w_q[W-1];
    // Final remainder lies in [0, Dn), so the low N bits are exact after add-back.
    assign rn    = w_q[N-1:0] + (neg_w ? dn_q : '0);
    assign rm    = rn >> sh_q;
    assign qm    = qp_q - qn_q - N'(neg_w);

    always_comb begin
        lz = '0;
        for (int i = 0; i < N; i++)
            if (ay[i]) lz = SW'(N - 1 - i);
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign tag_out     = tag_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        dl_d    = dl_q;
        dn_d    = dn_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        q_d     = q_q;
        r_d     = r_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dl_d    = x;
                dn_d    = y;
                sgn_d   = signed_in;
                tag_d   = tag_in;
                state_d = PREP;
            end
            PREP: if (dn_q == '0) begin
                q_d     = '1;
                r_d     = dl_q;
                dbz_d   = 1'b1;
                state_d = DONE;
            end else if (sgn_q && dl_q == MIN && &dn_q) begin
                q_d     = MIN;
                r_d     = '0;
                ovf_d   = 1'b1;
                state_d = DONE;
            end else begin
                // Divide (|x| << lz) by the normalised divisor; the high half seeds the remainder.
                qs_d    = sx ^ sy;
                rs_d    = sx;
                w_d     = W'(xs[2*N-1:N]);
                dl_d    = xs[N-1:0];
                dn_d    = ay << lz;
                sh_d    = lz;
                cnt_d   = SW'(N - 1);
                qp_d    = '0;
                qn_d    = '0;
                state_d = ITER;
            end
            ITER: begin
                w_d     = pos ? pw - dnw : neg ? pw + dnw : pw;
                qp_d    = {qp_q[N-2:0], pos};
                qn_d    = {qn_q[N-2:0], neg};
                dl_d    = dl_q << 1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : ITER;
            end
            FIX: begin
                q_d     = qs_q ? -qm : qm;
                r_d     = rs_q ? -rm : rm;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                q_d     = '0;
                r_d     = '0;
                tag_d   = '0;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dl_q    <= '0;
            dn_q    <= '0;
            qp_q    <= '0;
            qn_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            dl_q    <= dl_d;
            dn_q    <= dn_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            q_q     <= q_d;
            r_q     <= r_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tag_q   <= tag_d;
        end
    end
endmodule
